// File: rtl/aes_inv_subbytes_seq.sv
// aes_inv_subbytes_seq
// AES InvSubBytes over a 128-bit state behind a valid/ready handshake.
// Default build: four shared inverse S-box units, one column per BUSY cycle,
// so a result appears four edges after the accept edge.
// Define AES_INV_SUBBYTES_PARALLEL_EN to use sixteen units instead and finish
// the whole state in a single BUSY cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready is high only in IDLE. out_valid is high only in DONE, and
// state_out stays stable until the edge where out_ready is high. in_valid is
// ignored outside IDLE and out_ready is ignored outside DONE.
// FSM state is visible on the busy, in_ready and out_valid ports.
module aes_inv_subbytes_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] data_q, data_d;

    // GF(2^8) multiply, reduced modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (2+4+...+128); 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse affine transform, then field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

`ifdef AES_INV_SUBBYTES_PARALLEL_EN
    logic [127:0] sub_all;

    for (genvar g = 0; g < 16; g++) begin : g_unit
        assign sub_all[127-8*g -: 8] = inv_sbox(data_q[127-8*g -: 8]);
    end
`else
    logic [31:0] col_word;
    logic [31:0] sub_col;

    // Select the column being worked on this cycle.
    always_comb begin
        col_word = data_q[127:96];
        case (col_q)
            2'd0:    col_word = data_q[127:96];
            2'd1:    col_word = data_q[95:64];
            2'd2:    col_word = data_q[63:32];
            default: col_word = data_q[31:0];
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_unit
        assign sub_col[31-8*g -: 8] = inv_sbox(col_word[31-8*g -: 8]);
    end
`endif

    // State, column counter and working register; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            data_q  <= 128'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic and in-place substitution of the working register.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = state_in;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
`ifdef AES_INV_SUBBYTES_PARALLEL_EN
                data_d  = sub_all;
                state_d = DONE;
`else
                case (col_q)
                    2'd0:    data_d[127:96] = sub_col;
                    2'd1:    data_d[95:64]  = sub_col;
                    2'd2:    data_d[63:32]  = sub_col;
                    default: data_d[31:0]   = sub_col;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) state_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs come straight from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q == BUSY);
        out_valid = (state_q == DONE);
        state_out = data_q;
    end

endmodule
